// File: rtl/arbitro_ula.sv
`default_nettype none
// ============================================================================
// Module   : arbitro_ula
// Purpose  : Round-robin arbiter that shares one multi-cycle ALU between two
//            requesters, with registered operands and a held response.
// Revision : 1.0
// ============================================================================
module arbitro_ula #(
  parameter int CICLOS_ULA = 1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid0,
  input  logic       req_valid1,
  output logic       req_ready0,
  output logic       req_ready1,
  input  logic [2:0] op0,
  input  logic [2:0] op1,
  input  logic [7:0] a0,
  input  logic [7:0] b0,
  input  logic [7:0] a1,
  input  logic [7:0] b1,
  output logic [7:0] ula_entrada1,
  output logic [7:0] ula_entrada2,
  output logic [2:0] ula_sinal,
  input  logic [7:0] ula_saida,
  output logic       resp_valid0,
  output logic       resp_valid1,
  input  logic       resp_ready0,
  input  logic       resp_ready1,
  output logic [7:0] resp_resultado,
  output logic       resp_erro,
  output logic       ocupado
);

  localparam logic [1:0] LIVRE    = 2'd0;
  localparam logic [1:0] EXECUTA  = 2'd1;
  localparam logic [1:0] RESPONDE = 2'd2;
  localparam logic [1:0] CARGA    = 2'(CICLOS_ULA - 1);
  localparam logic [2:0] OP_MAX   = 3'b100;

  logic [1:0] estado;
  logic [1:0] contador;
  logic       ultimo;
  logic       dono;
  logic       op_invalida;
  logic       vencedor;
  logic       aceita;
  logic       resp_aceita;

  // On a tie the requester not served last wins.
  always_comb begin
    vencedor = 1'b0;
    if (req_valid0 && req_valid1) begin
      vencedor = ~ultimo;
    end else if (req_valid1) begin
      vencedor = 1'b1;
    end
  end

  assign req_ready0  = reset && (estado == LIVRE) && req_valid0 && !vencedor;
  assign req_ready1  = reset && (estado == LIVRE) && req_valid1 &&  vencedor;
  assign aceita      = req_ready0 || req_ready1;
  assign resp_valid0 = (estado == RESPONDE) && !dono;
  assign resp_valid1 = (estado == RESPONDE) &&  dono;
  assign resp_aceita = (estado == RESPONDE) && (dono ? resp_ready1 : resp_ready0);
  assign ocupado     = (estado != LIVRE);

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado         <= LIVRE;
      contador       <= 2'd0;
      ultimo         <= 1'b1;
      dono           <= 1'b0;
      op_invalida    <= 1'b0;
      ula_entrada1   <= 8'h00;
      ula_entrada2   <= 8'h00;
      ula_sinal      <= 3'b000;
      resp_resultado <= 8'h00;
      resp_erro      <= 1'b0;
    end else begin
      case (estado)
        LIVRE: begin
          if (aceita) begin
            dono     <= vencedor;
            contador <= CARGA;
            estado   <= EXECUTA;
            if (vencedor) begin
              ula_sinal    <= op1;
              ula_entrada1 <= a1;
              ula_entrada2 <= b1;
              op_invalida  <= (op1 > OP_MAX);
            end else begin
              ula_sinal    <= op0;
              ula_entrada1 <= a0;
              ula_entrada2 <= b0;
              op_invalida  <= (op0 > OP_MAX);
            end
          end
        end
        EXECUTA: begin
          if (contador == 2'd0) begin
            resp_resultado <= op_invalida ? 8'h00 : ula_saida;
            resp_erro      <= op_invalida;
            estado         <= RESPONDE;
          end else begin
            contador <= contador - 2'd1;
          end
        end
        RESPONDE: begin
          if (resp_aceita) begin
            ultimo    <= dono;
            resp_erro <= 1'b0;
            estado    <= LIVRE;
          end
        end
        default: estado <= LIVRE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_arbitro_ula.sv
`default_nettype none
// ============================================================================
// Module   : tb_arbitro_ula
// Purpose  : Directed bench for arbitro_ula with one- and three-cycle ALUs.
// Revision : 1.0
// ============================================================================
module tb_arbitro_ula;

  typedef struct {
    int         req;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] res;
    logic       err;
  } vec_t;

  logic       clock = 1'b0;
  logic       reset1, reset3;
  logic       req_valid0, req_valid1, resp_ready0, resp_ready1;
  logic [2:0] op0, op1;
  logic [7:0] a0, b0, a1, b1;
  logic       usa3;
  int         total = 0;
  int         bad = 0;

  logic       rr0_1, rr1_1, rv0_1, rv1_1, erro_1, ocup_1;
  logic       rr0_3, rr1_3, rv0_3, rv1_3, erro_3, ocup_3;
  logic [7:0] e1_1, e2_1, res_1, saida_1, e1_3, e2_3, res_3, saida_3;
  logic [2:0] sin_1, sin_3;

  logic       rr0, rr1, rv0, rv1, erro, ocup;
  logic [7:0] e1, e2, res;
  logic [2:0] sin;

  function automatic logic [7:0] alu(input logic [2:0] s, input logic [7:0] x, input logic [7:0] y);
    case (s)
      3'b000:  alu = x & y;
      3'b001:  alu = x | y;
      3'b010:  alu = x + y;
      3'b011:  alu = x - y;
      3'b100:  alu = {7'd0, x < y};
      default: alu = 8'hA5;
    endcase
  endfunction

  assign saida_1 = alu(sin_1, e1_1, e2_1);
  assign saida_3 = alu(sin_3, e1_3, e2_3);

  assign rr0  = usa3 ? rr0_3  : rr0_1;
  assign rr1  = usa3 ? rr1_3  : rr1_1;
  assign rv0  = usa3 ? rv0_3  : rv0_1;
  assign rv1  = usa3 ? rv1_3  : rv1_1;
  assign erro = usa3 ? erro_3 : erro_1;
  assign ocup = usa3 ? ocup_3 : ocup_1;
  assign e1   = usa3 ? e1_3   : e1_1;
  assign e2   = usa3 ? e2_3   : e2_1;
  assign res  = usa3 ? res_3  : res_1;
  assign sin  = usa3 ? sin_3  : sin_1;

  arbitro_ula #(.CICLOS_ULA(1)) dut1 (
    .clock(clock), .reset(reset1),
    .req_valid0(req_valid0), .req_valid1(req_valid1),
    .req_ready0(rr0_1), .req_ready1(rr1_1),
    .op0(op0), .op1(op1), .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .ula_entrada1(e1_1), .ula_entrada2(e2_1), .ula_sinal(sin_1), .ula_saida(saida_1),
    .resp_valid0(rv0_1), .resp_valid1(rv1_1),
    .resp_ready0(resp_ready0), .resp_ready1(resp_ready1),
    .resp_resultado(res_1), .resp_erro(erro_1), .ocupado(ocup_1)
  );

  arbitro_ula #(.CICLOS_ULA(3)) dut3 (
    .clock(clock), .reset(reset3),
    .req_valid0(req_valid0), .req_valid1(req_valid1),
    .req_ready0(rr0_3), .req_ready1(rr1_3),
    .op0(op0), .op1(op1), .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .ula_entrada1(e1_3), .ula_entrada2(e2_3), .ula_sinal(sin_3), .ula_saida(saida_3),
    .resp_valid0(rv0_3), .resp_valid1(rv1_3),
    .resp_ready0(resp_ready0), .resp_ready1(resp_ready1),
    .resp_resultado(res_3), .resp_erro(erro_3), .ocupado(ocup_3)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nome, got, exp);
    end
  endtask

  task automatic check_reset_values();
    chk("rst_resp_valid", {30'd0, rv1, rv0}, 32'd0);
    chk("rst_req_ready", {30'd0, rr1, rr0}, 32'd0);
    chk("rst_ocupado", {31'd0, ocup}, 32'd0);
    chk("rst_erro", {31'd0, erro}, 32'd0);
    chk("rst_resultado", {24'd0, res}, 32'd0);
    chk("rst_entradas", {16'd0, e1, e2}, 32'd0);
    chk("rst_sinal", {29'd0, sin}, 32'd0);
  endtask

  // Single-requester transaction: grant, latch, latency, response, release.
  task automatic txn(input int r, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] eres, input logic eerr);
    int n;
    @(negedge clock);
    if (r == 0) begin req_valid0 = 1'b1; op0 = op; a0 = a; b0 = b; end
    else        begin req_valid1 = 1'b1; op1 = op; a1 = a; b1 = b; end
    #1 chk("req_ready", {30'd0, rr1, rr0}, (r == 0) ? 32'd1 : 32'd2);
    @(posedge clock);
    n = 1;
    @(negedge clock);
    req_valid0 = 1'b0; req_valid1 = 1'b0;
    chk("latch", {13'd0, sin, e1, e2}, {13'd0, op, a, b});
    while (!(rv0 || rv1) && n < 12) begin
      @(posedge clock); n++; @(negedge clock);
    end
    chk("latencia", n, usa3 ? 32'd4 : 32'd2);
    chk("resp_valid", {30'd0, rv1, rv0}, (r == 0) ? 32'd1 : 32'd2);
    chk("resultado", {24'd0, res}, {24'd0, eres});
    chk("erro", {31'd0, erro}, {31'd0, eerr});
    chk("ocupado_resp", {31'd0, ocup}, 32'd1);
    if (r == 0) resp_ready0 = 1'b1; else resp_ready1 = 1'b1;
    @(posedge clock);
    @(negedge clock);
    resp_ready0 = 1'b0; resp_ready1 = 1'b0;
    chk("volta_livre", {29'd0, ocup, rv1, rv0}, 32'd0);
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{0, 3'b000, 8'hF0, 8'h3C, 8'h30, 1'b0};
    vecs[1] = '{1, 3'b001, 8'h0F, 8'hF0, 8'hFF, 1'b0};
    vecs[2] = '{0, 3'b010, 8'd200, 8'd100, 8'd44, 1'b0};
    vecs[3] = '{1, 3'b011, 8'd3, 8'd5, 8'hFE, 1'b0};
    vecs[4] = '{0, 3'b100, 8'd5, 8'd7, 8'd1, 1'b0};
    vecs[5] = '{1, 3'b100, 8'd7, 8'd5, 8'd0, 1'b0};
    vecs[6] = '{1, 3'b110, 8'h12, 8'h34, 8'h00, 1'b1};
    vecs[7] = '{0, 3'b111, 8'h55, 8'h66, 8'h00, 1'b1};

    usa3 = 1'b0; reset1 = 1'b0; reset3 = 1'b0;
    req_valid0 = 1'b1; req_valid1 = 1'b0; resp_ready0 = 1'b0; resp_ready1 = 1'b0;
    op0 = 3'b010; op1 = 3'b000; a0 = 8'd1; b0 = 8'd2; a1 = 8'd0; b1 = 8'd0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset_values();
    req_valid0 = 1'b0;
    reset1 = 1'b1;

    // Tie after reset: requester 0 first, response held, then requester 1.
    @(negedge clock);
    req_valid0 = 1'b1; op0 = 3'b011; a0 = 8'd5; b0 = 8'd3;
    req_valid1 = 1'b1; op1 = 3'b000; a1 = 8'hF0; b1 = 8'h3C;
    #1 chk("tie_ready", {30'd0, rr1, rr0}, 32'd1);
    @(posedge clock);
    @(negedge clock);
    req_valid0 = 1'b0;
    #1 chk("exec_ready", {30'd0, rr1, rr0}, 32'd0);
    @(posedge clock);
    @(negedge clock);
    chk("tie_rv0", {30'd0, rv1, rv0}, 32'd1);
    chk("tie_res0", {24'd0, res}, 32'd2);
    for (int i = 0; i < 5; i++) begin
      chk("hold_res", {24'd0, res}, 32'd2);
      chk("hold_ready1", {31'd0, rr1}, 32'd0);
      chk("hold_ocupado", {31'd0, ocup}, 32'd1);
      @(posedge clock);
      @(negedge clock);
    end
    chk("hold_rv0", {30'd0, rv1, rv0}, 32'd1);
    resp_ready0 = 1'b1;
    @(posedge clock);
    @(negedge clock);
    resp_ready0 = 1'b0;
    #1 chk("tie_ready1", {30'd0, rr1, rr0}, 32'd2);
    @(posedge clock);
    @(negedge clock);
    req_valid1 = 1'b0;
    @(posedge clock);
    @(negedge clock);
    chk("tie_rv1", {30'd0, rv1, rv0}, 32'd2);
    chk("tie_res1", {24'd0, res}, 32'h30);
    resp_ready0 = 1'b1;
    @(posedge clock);
    @(negedge clock);
    resp_ready0 = 1'b0;
    chk("nonowner_ready", {30'd0, rv1, rv0}, 32'd2);
    resp_ready1 = 1'b1;
    @(posedge clock);
    @(negedge clock);
    resp_ready1 = 1'b0;
    req_valid0 = 1'b1; req_valid1 = 1'b1;
    #1 chk("tie2_ready", {30'd0, rr1, rr0}, 32'd1);
    req_valid0 = 1'b0; req_valid1 = 1'b0;
    @(posedge clock);
    @(negedge clock);
    chk("withdraw_idle", {31'd0, ocup}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      txn(vecs[i].req, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].err);
    end

    // Pulse on req_valid0 while the ALU is busy must be ignored.
    @(negedge clock);
    req_valid1 = 1'b1; op1 = 3'b001; a1 = 8'h01; b1 = 8'h02;
    @(posedge clock);
    @(negedge clock);
    req_valid1 = 1'b0;
    req_valid0 = 1'b1; op0 = 3'b010; a0 = 8'd9; b0 = 8'd9;
    #1 chk("pulse_ready0", {31'd0, rr0}, 32'd0);
    @(posedge clock);
    @(negedge clock);
    req_valid0 = 1'b0;
    chk("pulse_rv1", {30'd0, rv1, rv0}, 32'd2);
    chk("pulse_res", {24'd0, res}, 32'h03);
    resp_ready1 = 1'b1;
    @(posedge clock);
    @(negedge clock);
    resp_ready1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("pulse_no_extra", {29'd0, ocup, rv1, rv0}, 32'd0);
      @(posedge clock);
      @(negedge clock);
    end

    // Three-cycle ALU: reset in the second execute cycle drops the transaction.
    usa3 = 1'b1; reset1 = 1'b0;
    reset3 = 1'b1;
    @(negedge clock);
    req_valid0 = 1'b1; op0 = 3'b010; a0 = 8'd10; b0 = 8'd20;
    @(posedge clock);
    @(negedge clock);
    req_valid0 = 1'b0;
    chk("c3_ocupado", {31'd0, ocup}, 32'd1);
    @(posedge clock);
    @(negedge clock);
    reset3 = 1'b0;
    @(posedge clock);
    @(negedge clock);
    req_valid1 = 1'b1;
    #1 check_reset_values();
    req_valid1 = 1'b0;
    reset3 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      @(negedge clock);
      chk("c3_dropped", {29'd0, ocup, rv1, rv0}, 32'd0);
    end
    txn(0, 3'b010, 8'd10, 8'd20, 8'd30, 1'b0);
    txn(1, 3'b011, 8'd0, 8'd1, 8'hFF, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
